spart_rx: RTL and testbench
===========================

SPART_RX -- requirements
Module: spart_rx

Interface
REQ-001 SHALL have parameter OVS, default 16, meaning enable ticks per bit period (power of two, 8 to 16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  one-clk-wide baud tick from the baud rate generator, OVS ticks per bit.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_read  input  1  single-cycle strobe from the bus interface; consumes the current byte.
REQ-007 SHALL have port rx_data  output  8  last completely received byte.
REQ-008 SHALL have port rda  output  1  receive data available.
REQ-009 SHALL have port overrun  output  1  a byte was completed while rda was set and not being read.
REQ-010 SHALL have port frame_err  output  1  the stop bit of the last delivered byte was sampled low.

Function
REQ-011 SHALL pass rxd through a two-flop synchronizer (rxd_s); all decisions use rxd_s, so rxd reaches the FSM 2 clk later.
REQ-012 SHALL have a tick counter of width log2(OVS), a 3-bit bit counter and an 8-bit shift register; all counters hold when enable=0.
REQ-013 SHALL implement states IDLE, START, DATA and STOP, and all FSM activity SHALL occur only on clocks where enable=1.
REQ-014 IDLE: on an enable tick with rxd_s=0 -> START, tick counter=0; otherwise remain in IDLE.
REQ-015 START: tick counter increments per tick; on the tick where it equals OVS/2-1 (mid start bit): rxd_s=0 -> DATA with tick counter=0 and bit counter=0; rxd_s=1 -> IDLE (glitch rejected, no flag raised).
REQ-016 DATA: on the tick where the tick counter equals OVS-1, SHALL shift rxd_s into shift[7] with shift right, clear the tick counter, and either increment the bit counter or, if it is 7, go to STOP; on other ticks SHALL increment the tick counter.
REQ-017 STOP: on the tick where the tick counter equals OVS-1, SHALL load rx_data<=shift, set rda<=1, set frame_err<=~rxd_s, set overrun<=(rda & ~rx_read), and go to IDLE.
REQ-018 A framing-error byte SHALL still be delivered; if the line remains low, IDLE SHALL treat the low level as a new start bit (no break detection).
REQ-019 rx_read=1 SHALL clear rda, overrun and frame_err on the same edge, unless REQ-017 completes on that edge.
REQ-020 If rx_read and STOP completion coincide, SHALL load the new byte, set rda=1, set overrun=0, and set frame_err from the new stop bit.
REQ-021 rx_data SHALL hold its value until the next STOP completion; rx_read SHALL NOT alter rx_data.
REQ-022 rx_read while rda=0 SHALL have no effect.
REQ-023 Sampling point SHALL be mid-bit: the start bit is confirmed at tick OVS/2, and each subsequent bit is sampled OVS ticks later.

Reset
REQ-024 rst SHALL force state=IDLE, all counters=0, shift=8'h00, rx_data=8'h00, rda=0, overrun=0, frame_err=0, and both synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame without raising any flag; after release, reception SHALL resume from IDLE on the next start edge.

Verification
REQ-026 With OVS=16 and enable every 4 clk, drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) at 16 ticks/bit -> rx_data=8'hA5, rda=1, frame_err=0, overrun=0 after the stop-bit mid tick.
REQ-027 Drive a 5-tick low pulse on idle rxd -> FSM returns to IDLE at tick 8, and rda, rx_data and all flags remain unchanged.
REQ-028 Receive 0x3C, leave it unread, then receive 0xC3 -> rx_data=8'hC3, rda=1, overrun=1; then pulse rx_read -> rda=0, overrun=0.
REQ-029 Send 0x55 with the stop bit held low -> rx_data=8'h55, frame_err=1; the following start detection begins from IDLE.
REQ-030 Pulse rx_read on the same clk as 0x81 stop completion while rda=1 -> rx_data=8'h81, rda=1, overrun=0.
REQ-031 Assert rst during data bit 4 of a frame, then send 0x0F -> no flags are raised by the aborted frame, and rx_data=8'h0F, rda=1.

Source files
------------

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer driven by an OVS-times oversampling baud tick.
// Delivers each completed byte with rda, overrun and framing-error flags.
module spart_rx #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       overrun,
  output logic       frame_err
);

  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] T_MID = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic          rxd_m, rxd_s;
  logic [TW-1:0] tick, tick_n;
  logic [2:0]    bitc, bitc_n;
  logic [7:0]    shift, shift_n;
  logic          done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_comb begin
    state_n = state;
    tick_n  = tick;
    bitc_n  = bitc;
    shift_n = shift;
    done    = 1'b0;
    if (enable) begin
      unique case (state)
        IDLE: begin
          if (!rxd_s) begin
            state_n = START;
            tick_n  = '0;
          end
        end
        START: begin
          if (tick == T_MID) begin
            tick_n  = '0;
            bitc_n  = '0;
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == T_END) begin
            shift_n = {rxd_s, shift[7:1]};
            tick_n  = '0;
            if (bitc == 3'd7) state_n = STOP;
            else              bitc_n  = bitc + 3'd1;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        STOP: begin
          if (tick == T_END) begin
            done    = 1'b1;
            tick_n  = '0;
            state_n = IDLE;
          end else begin
            tick_n = tick + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tick  <= '0;
      bitc  <= '0;
      shift <= 8'h00;
    end else begin
      state <= state_n;
      tick  <= tick_n;
      bitc  <= bitc_n;
      shift <= shift_n;
    end
  end

  // A completing byte wins over a coincident read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= 8'h00;
      rda       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (done) begin
      rx_data   <= shift;
      rda       <= 1'b1;
      frame_err <= ~rxd_s;
      overrun   <= rda & ~rx_read;
    end else if (rx_read) begin
      rda       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: directed and random 8N1 frames, scoreboard
// of expected deliveries popped by a monitor on rda/overrun rises.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable;
  logic       rxd = 1'b1;
  logic       rx_read = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       overrun;
  logic       frame_err;
  logic [1:0] ediv = 2'd0;

  spart_rx #(.OVS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rxd       (rxd),
    .rx_read   (rx_read),
    .rx_data   (rx_data),
    .rda       (rda),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ediv <= ediv + 2'd1;
  assign enable = (ediv == 2'd0);

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference view of the receiver's user-visible registers.
  logic [7:0] m_data = 8'h00;
  logic       m_rda = 1'b0;
  logic       m_ov = 1'b0;
  logic       m_fe = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rx_data"}, rx_data, m_data);
    chk({tag, ".rda"}, 8'(rda), 8'(m_rda));
    chk({tag, ".overrun"}, 8'(overrun), 8'(m_ov));
    chk({tag, ".frame_err"}, 8'(frame_err), 8'(m_fe));
  endtask

  // Consume n baud ticks; returns 1ns after the last ticking edge.
  task automatic ticks(input int n);
    repeat (n) begin
      do @(negedge clk); while (!enable);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_byte(input logic [7:0] b, input logic sb);
    exp_t e;
    e.d  = b;
    e.fe = ~sb;
    e.ov = m_rda;
    sbq.push_back(e);
    m_data = b;
    m_ov   = m_rda;
    m_rda  = 1'b1;
    m_fe   = ~sb;
  endtask

  task automatic drive_head(input logic [7:0] b);
    rxd = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      ticks(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic sb);
    expect_byte(b, sb);
    drive_head(b);
    rxd = sb;
    ticks(16);
    rxd = 1'b1;
    ticks(20);
  endtask

  task automatic do_read(input string tag);
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    if (m_rda) begin
      m_rda = 1'b0;
      m_ov  = 1'b0;
      m_fe  = 1'b0;
    end
    chk_model(tag);
    ticks(2);
  endtask

  initial begin : monitor
    logic p_rda, p_ov;
    exp_t e;
    p_rda = 1'b0;
    p_ov  = 1'b0;
    forever begin
      @(negedge clk);
      if ((rda && !p_rda) || (overrun && !p_ov)) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_delivery: got %h expected none",
                   rx_data);
        end else begin
          e = sbq.pop_front();
          chk("mon.rx_data", rx_data, e.d);
          chk("mon.rda", 8'(rda), 8'h01);
          chk("mon.frame_err", 8'(frame_err), 8'(e.fe));
          chk("mon.overrun", 8'(overrun), 8'(e.ov));
        end
      end
      p_rda = rda;
      p_ov  = overrun;
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [7:0] b;
    logic       sb;
    logic       rd;
    repeat (3) @(negedge clk);
    chk_model("reset");
    rst = 1'b0;
    ticks(4);

    send_frame(8'hA5, 1'b1);

    rxd = 1'b0;
    ticks(5);
    rxd = 1'b1;
    ticks(20);
    chk_model("glitch");

    do_read("read_a5");
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    chk_model("overrun");
    do_read("read_ovr");

    send_frame(8'h55, 1'b0);
    chk_model("frame_err");

    // 0x81 completes on the 9th tick of its stop bit; read on that edge.
    drive_head(8'h81);
    rxd = 1'b1;
    ticks(8);
    do @(negedge clk); while (!enable);
    rx_read = 1'b1;
    @(posedge clk);
    #1;
    rx_read = 1'b0;
    m_data = 8'h81;
    m_rda  = 1'b1;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    @(negedge clk);
    chk_model("coincident");
    ticks(24);

    rxd = 1'b0;
    ticks(16);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      ticks(16);
    end
    rxd = 1'b1;
    ticks(8);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_data = 8'h00;
    m_rda  = 1'b0;
    m_ov   = 1'b0;
    m_fe   = 1'b0;
    chk_model("abort");
    ticks(20);
    send_frame(8'h0F, 1'b1);
    do_read("read_0f");

    for (int n = 0; n < 24; n++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      if (m_rda && m_ov) rd = 1'b1;
      if (rd) do_read("rand_read");
      send_frame(b, sb);
    end
    chk_model("final");

    ticks(20);
    chk("scoreboard_empty", 8'(sbq.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
